// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot decoder/encoder pair.
// Both ends take their widths and the all-zero code from here so they agree.
package onehot_pkg;

  localparam int unsigned ONEHOT_N_IN      = 12;
  localparam int unsigned ONEHOT_N_OUT     = 4;
  localparam int unsigned ONEHOT_ERR_CNT_W = 8;

  // Code reported when no input bit is set.
  localparam logic [ONEHOT_N_OUT-1:0] ONEHOT_ZERO_CODE = 4'hF;

  // True when exactly one bit of the word is set.
  function automatic logic onehot_legal(input logic [ONEHOT_N_IN-1:0] word);
    return ($countones(word) == 1);
  endfunction

endpackage

// File: rtl/onehot_encoder_12to4_prio_enc.sv
// onehot_prio_enc: combinational lowest-set-bit encoder with legality detect.
// Ports:
//   onehot  in   N_IN   word to encode
//   code_c  out  N_OUT  index of lowest set bit, ZERO_CODE when none set
//   err_c   out  1      word is not exactly one-hot (zero or multi-bit)
// N_IN must match the package width because legality uses onehot_legal().
module onehot_prio_enc
  import onehot_pkg::*;
#(
  parameter int unsigned       N_IN      = ONEHOT_N_IN,
  parameter int unsigned       N_OUT     = ONEHOT_N_OUT,
  parameter logic [N_OUT-1:0]  ZERO_CODE = ONEHOT_ZERO_CODE
) (
  input  logic [N_IN-1:0]  onehot,
  output logic [N_OUT-1:0] code_c,
  output logic             err_c
);

  // Scan from the top down so the lowest set bit is the last write and wins.
  always_comb begin
    code_c = ZERO_CODE;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        code_c = N_OUT'(i);
      end
    end
    err_c = !onehot_legal(onehot);
  end

endmodule

// File: rtl/onehot_encoder_12to4.sv
// onehot_encoder_12to4: registered 12-bit one-hot to 4-bit binary encoder
// behind a valid/ready interface with a 2-entry skid buffer.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   in   input word present
//   in_ready   out  registered; high while the skid register is empty
//   in_onehot  in   N_IN one-hot word
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts
//   out_code   out  N_OUT binary index
//   out_err    out  word was not exactly one-hot
//   err_clr    in   clear the error counter (wins over an increment)
//   err_count  out  ERR_CNT_W saturating count of accepted illegal words
module onehot_encoder_12to4
  import onehot_pkg::*;
#(
  parameter int unsigned       N_IN      = ONEHOT_N_IN,
  parameter int unsigned       N_OUT     = ONEHOT_N_OUT,
  parameter logic [N_OUT-1:0]  ZERO_CODE = ONEHOT_ZERO_CODE,
  parameter int unsigned       ERR_CNT_W = ONEHOT_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_OUT-1:0]     out_code,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [N_OUT-1:0]     enc_code;
  logic                 enc_err;
  logic                 in_xfer;

  logic                 skid_valid;
  logic [N_OUT-1:0]     skid_code;
  logic                 skid_err;

  logic                 out_valid_n;
  logic [N_OUT-1:0]     out_code_n;
  logic                 out_err_n;
  logic                 skid_valid_n;
  logic [N_OUT-1:0]     skid_code_n;
  logic                 skid_err_n;
  logic                 in_ready_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  onehot_prio_enc #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .ZERO_CODE (ZERO_CODE)
  ) u_prio_enc (
    .onehot (in_onehot),
    .code_c (enc_code),
    .err_c  (enc_err)
  );

  assign in_xfer = in_valid && in_ready;

  // Next-state for the output/skid pair and the error counter.
  always_comb begin
    out_valid_n  = out_valid;
    out_code_n   = out_code;
    out_err_n    = out_err;
    skid_valid_n = skid_valid;
    skid_code_n  = skid_code;
    skid_err_n   = skid_err;
    err_count_n  = err_count;

    if (!out_valid || out_ready) begin
      // Output slot frees up this edge; skid (older) has precedence.
      // in_ready is low whenever the skid is full, so no input arrives then.
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_code_n   = skid_code;
        out_err_n    = skid_err;
        skid_valid_n = 1'b0;
      end else if (in_xfer) begin
        out_valid_n = 1'b1;
        out_code_n  = enc_code;
        out_err_n   = enc_err;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (in_xfer) begin
      // Output held by a stalled consumer: park the new word.
      skid_valid_n = 1'b1;
      skid_code_n  = enc_code;
      skid_err_n   = enc_err;
    end

    if (err_clr) begin
      err_count_n = '0;
    end else if (in_xfer && enc_err && (err_count != '1)) begin
      err_count_n = err_count + ERR_CNT_W'(1);
    end

    in_ready_n = !skid_valid_n;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_code  <= '0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b1;
      err_count  <= '0;
    end else begin
      out_valid  <= out_valid_n;
      out_code   <= out_code_n;
      out_err    <= out_err_n;
      skid_valid <= skid_valid_n;
      skid_code  <= skid_code_n;
      skid_err   <= skid_err_n;
      in_ready   <= in_ready_n;
      err_count  <= err_count_n;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_12to4.sv
module tb_onehot_encoder_12to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_onehot;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  onehot_encoder_12to4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0] code;
    logic       err;
  } exp_t;

  // Reference: isolate lowest set bit arithmetically, take its log2.
  function automatic exp_t ref_enc(input logic [11:0] w);
    exp_t        e;
    logic [11:0] lsb;
    lsb    = w & (~w + 12'd1);
    e.err  = ($countones(w) != 1);
    e.code = (w == 12'd0) ? 4'hF : 4'($clog2(lsb));
    return e;
  endfunction

  // Model: queue of words accepted but not yet consumed.
  exp_t        q[$];
  bit          live       = 1'b0;
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_code;
  logic        prev_err;
  int unsigned model_err  = 0;
  int          accepted   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (live) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("err_count", 32'(err_count), model_err);
      if (prev_stall) begin
        check("hold_code", 32'(out_code), 32'(prev_code));
        check("hold_err", 32'(out_err), 32'(prev_err));
      end
    end
    if (rst) begin
      q.delete();
      model_err  = 0;
      prev_stall = 1'b0;
      live       = 1'b1;
    end else if (live) begin
      prev_stall = out_valid && !out_ready;
      prev_code  = out_code;
      prev_err   = out_err;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL underflow: output transfer with no word outstanding at %0t", $time);
        end else begin
          e = q.pop_front();
          check("out_code", 32'(out_code), 32'(e.code));
          check("out_err", 32'(out_err), 32'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        e = ref_enc(in_onehot);
        q.push_back(e);
        accepted++;
        if (e.err && model_err < 255) model_err++;
      end
      if (err_clr) model_err = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until accepted; in_valid is left high.
  task automatic send(input logic [11:0] w);
    int b;
    bit acc;
    in_valid  = 1'b1;
    in_onehot = w;
    b = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      b++;
    end while (!acc && b < 500);
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: word %0h not accepted after %0d cycles", w, b);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_onehot = 12'h000;
  endtask

  task automatic drain();
    int b;
    out_ready = 1'b1;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (out_valid && b < 100);
    check("drain_empty", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int target;
    int cycles;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_onehot = 12'h000;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_code", 32'(out_code), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // Legal sweep, back-to-back
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send(12'd1 << k);
      check("sweep_code", 32'(out_code), 32'(k));
      check("sweep_err", 32'(out_err), 32'd0);
    end
    idle();
    drain();
    check("sweep_err_count", 32'(err_count), 32'd0);

    // Illegal words
    send(12'h000);
    check("zero_code", 32'(out_code), 32'hF);
    check("zero_err", 32'(out_err), 32'd1);
    send(12'h0A0);
    check("multi_code", 32'(out_code), 32'd5);
    check("multi_err", 32'(out_err), 32'd1);
    send(12'hC00);
    check("c00_code", 32'(out_code), 32'd10);
    check("c00_err", 32'(out_err), 32'd1);
    idle();
    drain();
    check("three_errs", 32'(err_count), 32'd3);

    // Backpressure: 3rd word held off while skid full
    out_ready = 1'b0;
    send(12'h001);
    send(12'h002);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_onehot = 12'h004;
    cyc(3);
    check("bp_held_code", 32'(out_code), 32'd0);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    check("bp_still_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(12'h004);
    idle();
    drain();
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Saturation then clear together with an illegal accept
    for (int i = 0; i < 300; i++) send(12'hFFF);
    idle();
    cyc(1);
    check("sat_255", 32'(err_count), 32'd255);
    err_clr = 1'b1;
    send(12'hFFF);
    err_clr = 1'b0;
    idle();
    check("clr_wins", 32'(err_count), 32'd0);
    drain();

    // Reset with output and skid both full
    out_ready = 1'b0;
    send(12'hFFF);
    send(12'h002);
    idle();
    check("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    send(12'h800);
    check("post_rst_code", 32'(out_code), 32'd11);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    idle();
    drain();

    // Random stalls against the model
    target = accepted + 10000;
    cycles = 0;
    while (accepted < target && cycles < 80000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 0) in_onehot = 12'd1 << $urandom_range(0, 11);
      else                           in_onehot = 12'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 99) == 0);
      cyc(1);
      cycles++;
    end
    if (accepted < target) begin
      n_checks++;
      $display("FAIL random_timeout: accepted %0d of %0d", accepted, target);
    end
    err_clr = 1'b0;
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_12to4.md
Name: onehot_encoder_12to4

Overview:
- Registered inverse of the team's 4-to-12 one-hot decoder: converts a 12-bit one-hot word back to a 4-bit binary index.
- Validates one-hot legality, flags and counts illegal words.
- Streams through a valid/ready interface with a 2-entry skid buffer, so it can sit between a one-hot producer (e.g. a ring/scan counter) and a binary consumer without combinational ready paths.

Parameters:
- N_IN, 12, one-hot input width; the index range 0..N_IN-1 must fit in N_OUT bits.
- N_OUT, 4, binary code width.
- ZERO_CODE, 4'hF, code emitted for an all-zero input.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept; registered, equals !skid_full
- in_onehot  in  N_IN  one-hot word
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts
- out_code  out  N_OUT  binary index
- out_err  out  1  word was not exactly one-hot
- err_clr  in  1  clear error counter
- err_count  out  ERR_CNT_W  saturating count of accepted illegal words

Behaviour:
- Reset, while rst=1 at posedge: out_valid=0, out_code=0, out_err=0, skid empty, in_ready=1 on the following cycle, err_count=0.
  - Reset mid-transfer drops both held words; no partial output.
  - Reset has priority over every other input.
- Encoding, combinational on in_onehot, then registered:
  - Exactly one bit k set: code=k, err=0.
  - No bit set: code=ZERO_CODE, err=1.
  - More than one bit set: code=index of lowest set bit, err=1. For example, 12'b0000_1010_0000 gives code=5.
- Handshake:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - out_code and out_err are held stable while out_valid&!out_ready.
  - in_onehot is ignored when no transfer occurs.
- Latency: a word accepted at edge N appears on out_valid/out_code at N+1, provided the output register is empty or draining at N.
- Storage is an output register plus one skid register.
  - Accept while output full and not draining: word goes to skid; in_ready=0 from the next cycle.
  - Output drains while skid full: skid moves to output; in_ready=1 next cycle.
  - Output drains and input accepted in the same cycle with skid empty: new word goes to output; no bubble.
  - Order is strictly preserved. No word is dropped or duplicated.
- Throughput: 1 word/cycle while out_ready=1.
- err_count:
  - Increments by 1 on each accepted input whose err=1.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr=1 forces 0 on the next edge and has priority over a simultaneous increment; that error is not counted.
- in_ready depends only on registers, never combinationally on out_ready.

Decomposition:
- Shared package onehot_pkg:
  - N_IN/N_OUT defaults and ZERO_CODE, shared with the 4-to-12 decoder so both ends agree.
  - Function onehot_legal(word) returning the popcount==1 check.
- One natural sub-module: onehot_prio_enc, the combinational lowest-set-bit encoder plus zero/multi-bit detect, producing {code, err}.
- The top level holds the skid buffer and the counter.

Test Plan:
- Sweep k=0..11 with in_onehot=1<<k and out_ready=1 continuously -> out_code=k one cycle after each accept, out_err=0, back-to-back with no bubbles, err_count=0.
- in_onehot=12'h000, then 12'h0A0, then 12'hC00 -> codes 4'hF/err=1, 5/err=1, 10/err=1; err_count=3.
- Feed 12'h001, 12'h002, 12'h004 back-to-back with out_ready=0 ->
  - in_ready falls after the 2nd accept, so the 3rd word is held off.
  - Output stable at code 0.
  - Then raise out_ready -> outputs 0, 1, 2 in order; in_ready returns high.
- Drive 300 illegal words (12'hFFF) -> err_count saturates at 255. Then pulse err_clr together with an illegal accept -> err_count=0.
- Assert rst for one cycle while out_valid=1 and the skid is full -> next cycle out_valid=0, in_ready=1, err_count=0; the first post-reset word 12'h800 gives code 11.
- Random valid/ready stalls over 10k words against a reference model -> output sequence matches exactly; out_code and out_err never change while out_valid&!out_ready.
